// File: rtl/adam_dift_pkg.sv
// rtl/adam_dift_pkg.sv - shared types and constants for the DIFT tag RAM
package adam_dift_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  strb_t;
    typedef logic [3:0]  tag_t;

    localparam int unsigned TAG_PER_BYTE   = 1;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [0:0] {
        SCRUB_RUN  = 1'b0,
        SCRUB_DONE = 1'b1
    } scrub_state_t;

endpackage

// File: rtl/adam_dift_tag_ram_if.sv
// rtl/adam_dift_tag_ram_if.sv - request/response bundle of the DIFT tag RAM
interface adam_dift_tag_ram_if #(
    parameter int unsigned CNT_W = 32
);
    import adam_dift_pkg::*;

    logic             req_i;
    addr_t            addr_i;
    logic             we_i;
    strb_t            be_i;
    data_t            wdata_i;
    logic             we_tag_i;
    logic             wdata_tag_i;
    logic             rvalid_o;
    data_t            rdata_o;
    tag_t             rdata_tag_o;
    logic             init_done_o;
    logic [CNT_W-1:0] tainted_loads_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, we_tag_i, wdata_tag_i,
        input  rvalid_o, rdata_o, rdata_tag_o, init_done_o, tainted_loads_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, we_tag_i, wdata_tag_i,
        output rvalid_o, rdata_o, rdata_tag_o, init_done_o, tainted_loads_o
    );

endinterface

// File: rtl/adam_dift_tag_scrub.sv
// rtl/adam_dift_tag_scrub.sv - post-reset tag clearing walker (ADAM_DIFT_TAG_SCRUB_EN)
module adam_dift_tag_scrub
    import adam_dift_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             scrub_we_o,
    output logic [IDX_W-1:0] scrub_idx_o,
    output logic             done_o
);

`ifdef ADAM_DIFT_TAG_SCRUB_EN
    localparam logic [0:0] ST_RUN  = SCRUB_RUN;
    localparam logic [0:0] ST_DONE = SCRUB_DONE;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             done_q;

    // Walk every word once, then park in DONE until the next reset
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == ST_RUN) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_DONE;
            end
        end
    end

    // State, pointer and a one-cycle-delayed done flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= (state_q == ST_DONE);
        end
    end

    assign scrub_we_o  = (state_q == ST_RUN);
    assign scrub_idx_o = ptr_q;
    assign done_o      = done_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;

    assign scrub_we_o  = 1'b0;
    assign scrub_idx_o = '0;
    assign done_o      = 1'b1;
`endif

endmodule

// File: rtl/adam_dift_tag_ram.sv
// rtl/adam_dift_tag_ram.sv - scratchpad RAM with per-byte taint tags (scrubber: ADAM_DIFT_TAG_SCRUB_EN)
module adam_dift_tag_ram
    import adam_dift_pkg::*;
#(
    parameter int unsigned SIZE  = 65536,
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    adam_dift_tag_ram_if.slave  bus
);

    localparam int unsigned DEPTH = SIZE / BYTES_PER_WORD;
    localparam int unsigned AW    = $clog2(SIZE);
    localparam int unsigned IDX_W = AW - 2;

    data_t data_mem [DEPTH];
    tag_t  tag_mem  [DEPTH];

    logic [IDX_W-1:0] idx;
    logic             wr_req;
    logic             rd_req;
    logic             scrub_we;
    logic [IDX_W-1:0] scrub_idx;
    logic             scrub_done;
    tag_t             tag_rd;

    logic             rvalid_q;
    data_t            rdata_q;
    tag_t             rdata_tag_q;
    logic [CNT_W-1:0] cnt_q;

    logic unused_addr;
    assign unused_addr = ^(bus.addr_i >> AW) ^ (^bus.addr_i[1:0]);

    assign idx    = bus.addr_i[AW-1:2];
    assign wr_req = bus.req_i & bus.we_i;
    assign rd_req = bus.req_i & ~bus.we_i;

    adam_dift_tag_scrub #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_scrub (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .scrub_we_o  (scrub_we),
        .scrub_idx_o (scrub_idx),
        .done_o      (scrub_done)
    );

    // Tags are hidden while the scrubber still owns the array
    assign tag_rd = scrub_we ? '0 : tag_mem[idx];

    // Data array: byte-enabled stores, never cleared
    always_ff @(posedge clk_i) begin
        if (wr_req) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be_i[i]) begin
                    data_mem[idx][8*i +: 8] <= bus.wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Tag array: scrub writes win, core tag writes are dropped while scrubbing
    always_ff @(posedge clk_i) begin
        if (scrub_we) begin
            tag_mem[scrub_idx] <= '0;
        end else if (wr_req && bus.we_tag_i) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.be_i[i]) begin
                    tag_mem[idx][i] <= bus.wdata_tag_i;
                end
            end
        end
    end

    // Response registers and saturating tainted-load counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rdata_tag_q <= '0;
            cnt_q       <= '0;
        end else begin
            rvalid_q <= bus.req_i;
            if (rd_req) begin
                rdata_q     <= data_mem[idx];
                rdata_tag_q <= tag_rd;
                if ((tag_rd != '0) && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.rvalid_o        = rvalid_q;
    assign bus.rdata_o         = rdata_q;
    assign bus.rdata_tag_o     = rdata_tag_q;
    assign bus.tainted_loads_o = cnt_q;
    assign bus.init_done_o     = scrub_done;

endmodule

// File: tb/tb_adam_dift_tag_ram.sv
// tb/tb_adam_dift_tag_ram.sv - randomized self-checking bench for adam_dift_tag_ram
module tb_adam_dift_tag_ram;
    import adam_dift_pkg::*;

    localparam int unsigned SIZE    = 1024;
    localparam int unsigned DEPTH   = SIZE / 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    adam_dift_tag_ram_if #(.CNT_W(CNT_W)) bus ();

    adam_dift_tag_ram #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // edges seen since reset was last sampled high
    int edge_cnt = 0;
    always @(posedge clk) begin
        if (rst) edge_cnt = 0;
        else     edge_cnt = edge_cnt + 1;
    end

    logic [31:0] m_data [DEPTH];
    logic [3:0]  m_tag  [DEPTH];
    int          m_cnt = 0;
    logic [31:0] exp_rdata = '0;
    logic [3:0]  exp_rtag = '0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic issue(input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input bit wt, input bit tg);
        int w;
        bit scrub_on;
        w = int'(addr[9:2]);
`ifdef ADAM_DIFT_TAG_SCRUB_EN
        scrub_on = (edge_cnt + 1 <= int'(DEPTH));
`else
        scrub_on = 1'b0;
`endif
        bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = addr; bus.be_i = be;
        bus.wdata_i = wd; bus.we_tag_i = wt; bus.wdata_tag_i = tg;
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    m_data[w][8*b +: 8] = wd[8*b +: 8];
                    if (wt && !scrub_on) m_tag[w][b] = tg;
                end
            end
        end else begin
            exp_rdata = m_data[w];
            exp_rtag  = scrub_on ? 4'h0 : m_tag[w];
            if (exp_rtag != 4'h0 && m_cnt < CNT_MAX) m_cnt++;
        end
        @(posedge clk); #1;
        bus.req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 0; bus.we_i = 0; bus.addr_i = 0; bus.be_i = 0;
        bus.wdata_i = 0; bus.we_tag_i = 0; bus.wdata_tag_i = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid_o); end
        n_checks++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata_o); end
        n_checks++; if (bus.rdata_tag_o !== 4'h0) begin n_fail++; $display("FAIL reset_rtag: got %h want 0", bus.rdata_tag_o); end
        n_checks++; if (bus.tainted_loads_o !== 4'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", bus.tainted_loads_o); end
`ifdef ADAM_DIFT_TAG_SCRUB_EN
        n_checks++; if (bus.init_done_o !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", bus.init_done_o); end
`else
        n_checks++; if (bus.init_done_o !== 1'b1) begin n_fail++; $display("FAIL reset_init_done: got %b want 1", bus.init_done_o); end
`endif
        m_cnt = 0; exp_rdata = '0; exp_rtag = '0;
        rst = 1'b0;
    endtask

    task automatic test_scrub();
`ifdef ADAM_DIFT_TAG_SCRUB_EN
        int n;
        issue(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 1'b0);
        n = 1;
        n_checks++; if (bus.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL scrub_load_rvalid: got %b want 1", bus.rvalid_o); end
        n_checks++; if (bus.rdata_tag_o !== 4'h0) begin n_fail++; $display("FAIL scrub_load_tag: got %h want 0", bus.rdata_tag_o); end
        n_checks++; if (bus.init_done_o !== 1'b0) begin n_fail++; $display("FAIL scrub_early_done: got %b want 0", bus.init_done_o); end
        issue(1'b1, 32'h0, 4'hF, 32'h12345678, 1'b1, 1'b1);
        n = 2;
        while (bus.init_done_o !== 1'b1 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++; if (n != int'(DEPTH) + 1) begin n_fail++; $display("FAIL scrub_duration: got %0d cycles want %0d", n, DEPTH + 1); end
        issue(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (bus.rdata_o !== 32'h12345678) begin n_fail++; $display("FAIL scrub_data_kept: got %h want 12345678", bus.rdata_o); end
        n_checks++; if (bus.rdata_tag_o !== 4'h0) begin n_fail++; $display("FAIL scrub_tag_dropped: got %h want 0", bus.rdata_tag_o); end
`else
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.init_done_o !== 1'b1) begin n_fail++; $display("FAIL no_scrub_done: got %b want 1", bus.init_done_o); end
`endif
    endtask

    task automatic test_fill();
        for (int w = 0; w < int'(DEPTH); w++) begin
            issue(1'b1, 32'(w * 4), 4'hF, $urandom, 1'b1, 1'b0);
            n_checks++; if (bus.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL fill_rvalid w%0d: got %b want 1", w, bus.rvalid_o); end
            n_checks++; if (bus.rdata_o !== exp_rdata) begin n_fail++; $display("FAIL fill_rdata_hold w%0d: got %h want %h", w, bus.rdata_o, exp_rdata); end
        end
    endtask

    task automatic test_basic();
        int c0;
        c0 = m_cnt;
        issue(1'b1, 32'h40, 4'hF, 32'hDEADBEEF, 1'b1, 1'b1);
        issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_full_data: got %h want deadbeef", bus.rdata_o); end
        n_checks++; if (bus.rdata_tag_o !== 4'hF) begin n_fail++; $display("FAIL basic_full_tag: got %h want f", bus.rdata_tag_o); end
        n_checks++; if (bus.tainted_loads_o !== 4'(c0 + 1)) begin n_fail++; $display("FAIL basic_cnt1: got %0d want %0d", bus.tainted_loads_o, c0 + 1); end
        issue(1'b1, 32'h40, 4'b0011, 32'h11223344, 1'b1, 1'b0);
        issue(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (bus.rdata_o !== 32'hDEAD3344) begin n_fail++; $display("FAIL basic_partial_data: got %h want dead3344", bus.rdata_o); end
        n_checks++; if (bus.rdata_tag_o !== 4'b1100) begin n_fail++; $display("FAIL basic_partial_tag: got %b want 1100", bus.rdata_tag_o); end
        n_checks++; if (bus.tainted_loads_o !== 4'(c0 + 2)) begin n_fail++; $display("FAIL basic_cnt2: got %0d want %0d", bus.tainted_loads_o, c0 + 2); end
        issue(1'b1, 32'h80, 4'hF, 32'hAAAAAAAA, 1'b1, 1'b1);
        issue(1'b1, 32'h80, 4'hF, 32'h55555555, 1'b0, 1'b0);
        n_checks++; if (bus.rdata_o !== 32'hDEAD3344) begin n_fail++; $display("FAIL basic_store_hold: got %h want dead3344", bus.rdata_o); end
        issue(1'b0, 32'hABCD_0080, 4'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (bus.rdata_o !== 32'h55555555) begin n_fail++; $display("FAIL basic_notag_data: got %h want 55555555", bus.rdata_o); end
        n_checks++; if (bus.rdata_tag_o !== 4'hF) begin n_fail++; $display("FAIL basic_notag_tag: got %h want f", bus.rdata_tag_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        a = 32'($urandom_range(0, DEPTH - 1) * 4);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) issue(1'b1, a, 4'($urandom), $urandom, 1'b1, 1'($urandom));
            else            issue(1'b0, a, 4'h0, 32'h0, 1'b0, 1'b0);
            n_checks++; if (bus.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid k%0d: got %b want 1", k, bus.rvalid_o); end
            n_checks++; if (bus.rdata_o !== exp_rdata) begin n_fail++; $display("FAIL b2b_rdata k%0d: got %h want %h", k, bus.rdata_o, exp_rdata); end
            n_checks++; if (bus.rdata_tag_o !== exp_rtag) begin n_fail++; $display("FAIL b2b_rtag k%0d: got %h want %h", k, bus.rdata_tag_o, exp_rtag); end
        end
        @(posedge clk); #1;
        n_checks++; if (bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_rvalid: got %b want 0", bus.rvalid_o); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
                n_checks++; if (bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_rvalid k%0d: got %b want 0", k, bus.rvalid_o); end
            end
            issue(1'($urandom), $urandom, 4'($urandom), $urandom, 1'($urandom), 1'($urandom));
            n_checks++; if (bus.rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rnd_rvalid k%0d: got %b want 1", k, bus.rvalid_o); end
            n_checks++; if (bus.rdata_o !== exp_rdata) begin n_fail++; $display("FAIL rnd_rdata k%0d: got %h want %h", k, bus.rdata_o, exp_rdata); end
            n_checks++; if (bus.rdata_tag_o !== exp_rtag) begin n_fail++; $display("FAIL rnd_rtag k%0d: got %h want %h", k, bus.rdata_tag_o, exp_rtag); end
            n_checks++; if (bus.tainted_loads_o !== 4'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt k%0d: got %0d want %0d", k, bus.tainted_loads_o, m_cnt); end
        end
    endtask

    task automatic test_saturate();
        issue(1'b1, 32'h3F0, 4'hF, 32'h0BADF00D, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            issue(1'b0, 32'h3F0, 4'h0, 32'h0, 1'b0, 1'b0);
            n_checks++; if (bus.tainted_loads_o !== 4'(m_cnt)) begin n_fail++; $display("FAIL sat_cnt k%0d: got %0d want %0d", k, bus.tainted_loads_o, m_cnt); end
        end
        n_checks++; if (bus.tainted_loads_o !== 4'hF) begin n_fail++; $display("FAIL sat_final: got %0d want 15", bus.tainted_loads_o); end
    endtask

    task automatic test_reset_mid();
        int n;
        issue(1'b1, 32'h200, 4'hF, 32'hFEEDC0DE, 1'b1, 1'b1);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h200;
        rst = 1'b1;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        n_checks++; if (bus.rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid: got %b want 0", bus.rvalid_o); end
        n_checks++; if (bus.rdata_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0", bus.rdata_o); end
        n_checks++; if (bus.tainted_loads_o !== 4'h0) begin n_fail++; $display("FAIL rstmid_cnt: got %0d want 0", bus.tainted_loads_o); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = 0; exp_rdata = '0; exp_rtag = '0;
`ifdef ADAM_DIFT_TAG_SCRUB_EN
        for (int w = 0; w < int'(DEPTH); w++) m_tag[w] = 4'h0;
`endif
        n = 0;
        while (bus.init_done_o !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++; if (bus.init_done_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_init_timeout: got %b want 1", bus.init_done_o); end
        issue(1'b0, 32'h200, 4'h0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (bus.rdata_o !== 32'hFEEDC0DE) begin n_fail++; $display("FAIL rstmid_data_kept: got %h want feedc0de", bus.rdata_o); end
        n_checks++; if (bus.rdata_tag_o !== exp_rtag) begin n_fail++; $display("FAIL rstmid_tag: got %h want %h", bus.rdata_tag_o, exp_rtag); end
        n_checks++; if (bus.tainted_loads_o !== 4'(m_cnt)) begin n_fail++; $display("FAIL rstmid_cnt_after: got %0d want %0d", bus.tainted_loads_o, m_cnt); end
    endtask

    initial begin
        test_reset();
        test_scrub();
        test_fill();
        test_basic();
        test_back_to_back();
        test_random();
        test_saturate();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
